// File: rtl/step_clock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : step_clock_ctrl_if
// Brief    : Control/status bundle between the processor clock controller
//            and the board-level logic (mode select, button, clock, status).
// Revision : 1.0 - initial release
// ============================================================================
interface step_clock_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       mode;
  logic             step_btn;
  logic             cpu_clk;
  logic             cpu_tick;
  logic             busy;
  logic             btn_db;
  logic [CNT_W-1:0] cycle_count;

  // Board side: selects the mode, owns the button, observes the clock/status
  modport master (
    output mode, step_btn,
    input  cpu_clk, cpu_tick, busy, btn_db, cycle_count
  );

  // Controller side
  modport slave (
    input  mode, step_btn,
    output cpu_clk, cpu_tick, busy, btn_db, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/step_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_clock_ctrl
// Brief    : Glitch-free processor clock generator with halt, debounced
//            single-step, slow free-run and fast free-run modes, plus a
//            retired-cycle counter for the debug display.
//            Optional feature macro: STEP_CYCLE_COUNT_EN (builds cycle_count;
//            when undefined cycle_count is tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_W         = 4,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 32
) (
  input  wire logic        SYS_clk,
  input  wire logic        SYS_reset,
  step_clock_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int DV_W = $clog2(RUN_DIV);

  localparam logic [DB_W-1:0] c_db_limit = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] c_db_one   = DB_W'(1);
  localparam logic [PH_W-1:0] c_ph_last  = PH_W'(PULSE_W - 1);
  localparam logic [PH_W-1:0] c_ph_one   = PH_W'(1);
  localparam logic [DV_W-1:0] c_dv_last  = DV_W'(RUN_DIV - 1);
  localparam logic [DV_W-1:0] c_dv_one   = DV_W'(1);

  localparam logic [1:0] c_mode_step = 2'b01;
  localparam logic [1:0] c_mode_slow = 2'b10;
  localparam logic [1:0] c_mode_fast = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  logic            r_s1, r_s2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db, r_btn_db_q;
  logic [DV_W-1:0] r_div;
  state_t          r_state, w_state_nxt;
  logic [PH_W-1:0] r_ph, w_ph_nxt;
  logic            w_start, w_go, w_press;
  logic            r_cpu_clk, r_cpu_tick, r_busy;

  // Two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= bus.step_btn;
      r_s2 <= r_s1;
    end
  end

  // Debouncer: the synchronised level must disagree with btn_db through
  // DEBOUNCE_CYCLES counted edges before it is taken as the new level
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b1;
      r_btn_db_q <= 1'b1;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_limit) begin
        r_btn_db <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_one;
      end
    end
  end

  // Only a falling debounced level is a press; releases produce nothing
  assign w_press = r_btn_db_q & ~r_btn_db;

  // Slow-run divider, free-running only while slow mode is selected
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_div <= '0;
    end else if (bus.mode != c_mode_slow || r_div == c_dv_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_dv_one;
    end
  end

  assign w_go = ((bus.mode == c_mode_step) && w_press)
              || ((bus.mode == c_mode_slow) && (r_div == c_dv_last))
              || (bus.mode == c_mode_fast);

  // Next-state logic; mode is only consulted in IDLE or at the end of LOW
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_HIGH;
          w_ph_nxt    = '0;
          w_start     = 1'b1;
        end
      end
      ST_HIGH: begin
        if (r_ph == c_ph_last) begin
          w_state_nxt = ST_LOW;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + c_ph_one;
        end
      end
      ST_LOW: begin
        if (r_ph == c_ph_last) begin
          w_ph_nxt = '0;
          if (bus.mode == c_mode_fast) begin
            w_state_nxt = ST_HIGH;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_ph_nxt = r_ph + c_ph_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ph_nxt    = '0;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they come
  // straight off flops and line up with the state they describe
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_state    <= ST_IDLE;
      r_ph       <= '0;
      r_cpu_clk  <= 1'b0;
      r_cpu_tick <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cpu_clk  <= (w_state_nxt == ST_HIGH);
      r_cpu_tick <= w_start;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef STEP_CYCLE_COUNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  logic [CNT_W-1:0] r_cycle_count;

  // Retired-cycle counter, advanced together with cpu_tick; wraps naturally
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_cycle_count <= '0;
    end else if (w_start) begin
      r_cycle_count <= r_cycle_count + c_cnt_one;
    end
  end

  assign bus.cycle_count = r_cycle_count;
`else
  assign bus.cycle_count = {CNT_W{1'b0}};
`endif

  assign bus.cpu_clk  = r_cpu_clk;
  assign bus.cpu_tick = r_cpu_tick;
  assign bus.busy     = r_busy;
  assign bus.btn_db   = r_btn_db;

endmodule
`default_nettype wire
